// File: rtl/result_select_if.sv
// Execute-stage handshake bundle: upstream operation/operands in, registered writeback result out.
// The master side drives operations and accepts results; the slave side is the selector.
interface result_select_if #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [FUNCT_W-1:0] funct;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH-1:0]   shift_out;
  logic [WIDTH-1:0]   rs_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_wr;
  logic               out_illegal;

  modport master (
    output in_valid, funct, alu_out, shift_out, rs_data, out_ready,
    input  in_ready, out_valid, out_data, out_wr, out_illegal
  );

  modport slave (
    input  in_valid, funct, alu_out, shift_out, rs_data, out_ready,
    output in_ready, out_valid, out_data, out_wr, out_illegal
  );
endinterface

// File: rtl/result_select_unit.sv
// Writeback result selector for the execute stage: picks ALU/shift/HI/LO by funct,
// owns HI/LO, interlocks HI/LO users against an in-flight divide, one valid/ready output stage.
module result_select_unit #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  result_select_if.slave    rs,
  input  logic              div_done,
  input  logic [WIDTH-1:0]  div_quot,
  input  logic [WIDTH-1:0]  div_rem,
  output logic              hilo_busy,
  output logic [WIDTH-1:0]  hi_q,
  output logic [WIDTH-1:0]  lo_q
);

  localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] F_SLL  = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_SRL  = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] F_MFHI = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] F_MTHI = FUNCT_W'(6'b010001);
  localparam logic [FUNCT_W-1:0] F_MFLO = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] F_MTLO = FUNCT_W'(6'b010011);
  localparam logic [FUNCT_W-1:0] F_DIVU = FUNCT_W'(6'b011011);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_wr_q,    out_wr_d;
  logic             out_ill_q,   out_ill_d;
  logic             busy_q,      busy_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] hi_fwd, lo_fwd;
  logic             div_wr, hilo_op, hazard, accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_wr, sel_ill;

  // A div_done with nothing outstanding is a stray pulse and must not touch HI/LO.
  assign div_wr = div_done & busy_q;
  assign hi_fwd = div_wr ? div_rem  : hi_q;
  assign lo_fwd = div_wr ? div_quot : lo_q;

  assign hilo_op = (rs.funct == F_MFHI) | (rs.funct == F_MFLO) | (rs.funct == F_MTHI) |
                   (rs.funct == F_MTLO) | (rs.funct == F_DIVU);
  assign hazard  = busy_q & ~div_done & hilo_op;
  assign rs.in_ready = (~out_valid_q | rs.out_ready) & ~hazard;
  assign accept      = rs.in_valid & rs.in_ready;

  always_comb begin
    sel_data = '0;
    sel_wr   = 1'b0;
    sel_ill  = 1'b0;
    case (rs.funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin
        sel_data = rs.alu_out;
        sel_wr   = 1'b1;
      end
      F_SLL, F_SRL: begin
        sel_data = rs.shift_out;
        sel_wr   = 1'b1;
      end
      F_MFHI: begin
        sel_data = hi_fwd;
        sel_wr   = 1'b1;
      end
      F_MFLO: begin
        sel_data = lo_fwd;
        sel_wr   = 1'b1;
      end
      F_MTHI, F_MTLO, F_DIVU: ;
      default: sel_ill = 1'b1;
    endcase
  end

  always_comb begin
    hi_d        = hi_fwd;
    lo_d        = lo_fwd;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_wr_d    = out_wr_q;
    out_ill_d   = out_ill_q;
    if (div_done) busy_d = 1'b0;
    if (out_valid_q & rs.out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_wr_d    = sel_wr;
      out_ill_d   = sel_ill;
      // A move accepted alongside div_done is younger than the divide, so it wins.
      if (rs.funct == F_MTHI) hi_d = rs.rs_data;
      if (rs.funct == F_MTLO) lo_d = rs.rs_data;
      if (rs.funct == F_DIVU) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_wr_q    <= 1'b0;
      out_ill_q   <= 1'b0;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_wr_q    <= out_wr_d;
      out_ill_q   <= out_ill_d;
      busy_q      <= busy_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign rs.out_valid   = out_valid_q;
  assign rs.out_data    = out_data_q;
  assign rs.out_wr      = out_wr_q;
  assign rs.out_illegal = out_ill_q;
  assign hilo_busy      = busy_q;

endmodule
